md_sequencer: RTL and testbench
===============================

// Module: md_sequencer
// PURPOSE
//  Iterative multiply/divide sequencer beside the execute-stage ALU.
//  Runs MULT/MULTU/DIV/DIVU as a shift-add / restoring-divide FSM over WIDTH cycles.
//  Results go into architectural HI/LO registers.
//  Raises stall toward the pipeline when an HI/LO read or a new md op arrives while busy.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO are WIDTH each, product is 2*WIDTH
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      reset, asynchronous, active-high
//  start        in   1      issue md op this cycle (from execute decode)
//  md_op        in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  rs           in   WIDTH  operand A (dividend / multiplicand)
//  rt           in   WIDTH  operand B (divisor / multiplier)
//  hilo_rd      in   1      instruction in execute reads HI or LO (MFHI/MFLO)
//  busy         out  1      op in progress (CALC or FIX)
//  stall        out  1      busy & (hilo_rd | start); combinational
//  done         out  1      one-cycle pulse: HI/LO just updated
//  div_by_zero  out  1      sticky for last op: DIV/DIVU with rt==0
//  hi           out  WIDTH  HI register (remainder / upper product)
//  lo           out  WIDTH  LO register (quotient / lower product)
// BEHAVIOUR
//  Reset (async, any state):
//   - state=IDLE, count=0
//   - hi=lo=0; busy=done=div_by_zero=0
//   - an in-flight op is discarded
//  States: IDLE, CALC, FIX, DONE.
//  - start is accepted only in IDLE or DONE; ignored in CALC/FIX (stall=1 tells issuer to hold).
//  - Accept: latch op; latch |rs|, |rt| (signed ops) or raw rs, rt (unsigned);
//    record result signs; count<=0; clear div_by_zero.
//    - DIV/DIVU with rt==0 -> DONE directly:
//      hi<=rs, lo<={WIDTH{1'b1}}, div_by_zero<=1.
//    - otherwise -> CALC.
//  - CALC: one bit per cycle, count increments.
//    - multiply: 2*WIDTH accumulator.
//    - divide: restoring; remainder WIDTH+1 bits.
//    - at count==WIDTH-1 -> FIX.
//  - FIX: apply signs (mod 2^WIDTH / 2^2WIDTH two's complement).
//    - MULT: negate 64-bit product if rs_sign^rt_sign.
//    - DIV: quotient negated if rs_sign^rt_sign; remainder takes sign of rs.
//    - -2^(W-1) / -1 -> lo=0x80000000, hi=0 (defined, no trap).
//    - write hi/lo; -> DONE.
//  - DONE: done=1 for exactly this cycle; start accepted here as in IDLE; else -> IDLE.
//  Latency: start in cycle 0 -> busy cycles 1..WIDTH+1 -> done and new hi/lo in cycle WIDTH+2 (34).
//  Divide-by-zero latency: done in cycle 1, busy never asserts.
//  hi/lo hold their value except on FIX->DONE or the div-by-zero accept; never partially updated.
//  busy=1 in CALC/FIX only; stall never asserts in IDLE/DONE.
//  Simultaneous hilo_rd and start while busy: single stall, both held by pipeline.
//  Operands change after accept: no effect (latched).
// TESTING
//  1 MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> cycle 34: done=1, hi=0xFFFFFFFE, lo=0x00000001
//  2 MULT rs=-3 rt=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV rs=-7 rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF
//  3 DIVU rs=100 rt=0 -> cycle 1: done=1, div_by_zero=1, hi=0x64, lo=0xFFFFFFFF, busy never 1
//  4 MULTU 6*7, start again + hilo_rd at cycle 5 -> stall=1 cycles 5..; 2nd start ignored; hi=0, lo=42 at cycle 34
//  5 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; back-to-back start in DONE cycle accepted
//  6 DIVU 1000/3, assert rst in cycle 10 -> same cycle busy=0, hi=lo=0; next start runs normally

Source files
------------

// File: rtl/md_if.sv
// Handshake and result bundle between the execute stage and the multiply/divide sequencer.
interface md_if #(parameter int WIDTH = 32);
   logic             start;
   logic [1:0]       md_op;
   logic [WIDTH-1:0] rs;
   logic [WIDTH-1:0] rt;
   logic             hilo_rd;
   logic             busy;
   logic             stall;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output start, md_op, rs, rt, hilo_rd,
                   input  busy, stall, done, div_by_zero, hi, lo);
   modport slave  (input  start, md_op, rs, rt, hilo_rd,
                   output busy, stall, done, div_by_zero, hi, lo);
endinterface

// File: rtl/md_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit: shift-add multiply, restoring divide, one bit per cycle,
// results committed to HI/LO in one shot.
//  state  | meaning
//  IDLE   | waiting for start
//  CALC   | one product/quotient bit per cycle on magnitudes
//  FIX    | apply result signs, write HI/LO
//  DONE   | HI/LO just updated; start may be accepted again
module md_sequencer #(parameter int WIDTH = 32) (
   input logic  clk,
   input logic  rst,
   md_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      count_q, count_d;
   logic [1:0]         op_q, op_d;
   logic [WIDTH-1:0]   opa_q, opa_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic               rs_sign_q, rs_sign_d;
   logic               rt_sign_q, rt_sign_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH:0]     rem_q, rem_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               dbz_q, dbz_d;

   logic               signed_op;
   logic [WIDTH-1:0]   abs_rs, abs_rt;
   logic [WIDTH:0]     msum, trial, diff;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      op_d      = op_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      rs_sign_d = rs_sign_q;
      rt_sign_d = rt_sign_q;
      acc_d     = acc_q;
      rem_d     = rem_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      dbz_d     = dbz_q;

      signed_op = ~bus.md_op[0];
      abs_rs    = (signed_op && bus.rs[WIDTH-1]) ? ({WIDTH{1'b0}} - bus.rs) : bus.rs;
      abs_rt    = (signed_op && bus.rt[WIDTH-1]) ? ({WIDTH{1'b0}} - bus.rt) : bus.rt;

      msum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opa_q : {WIDTH{1'b0}})};
      trial = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
      diff  = trial - {1'b0, opb_q};

      // Magnitude results converted back to two's complement; -2^(W-1)/-1 wraps naturally.
      prod_fix = (rs_sign_q ^ rt_sign_q) ? ({2*WIDTH{1'b0}} - acc_q) : acc_q;
      quo_fix  = (rs_sign_q ^ rt_sign_q) ? ({WIDTH{1'b0}} - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
      rem_fix  = rs_sign_q ? ({WIDTH{1'b0}} - rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (bus.start) begin
               op_d      = bus.md_op;
               opa_d     = abs_rs;
               opb_d     = abs_rt;
               rs_sign_d = signed_op & bus.rs[WIDTH-1];
               rt_sign_d = signed_op & bus.rt[WIDTH-1];
               count_d   = '0;
               dbz_d     = 1'b0;
               rem_d     = '0;
               acc_d     = bus.md_op[1] ? {{WIDTH{1'b0}}, abs_rs} : {{WIDTH{1'b0}}, abs_rt};
               if (bus.md_op[1] && bus.rt == '0) begin
                  hi_d    = bus.rs;
                  lo_d    = {WIDTH{1'b1}};
                  dbz_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (op_q[1]) begin
               rem_d              = diff[WIDTH] ? trial : diff;
               acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], ~diff[WIDTH]};
            end else begin
               acc_d = {msum, acc_q[WIDTH-1:1]};
            end
            count_d = count_q + CW'(1);
            if (count_q == CW'(WIDTH-1)) state_d = S_FIX;
         end
         S_FIX: begin
            if (op_q[1]) begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end else begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         op_q      <= '0;
         opa_q     <= '0;
         opb_q     <= '0;
         rs_sign_q <= 1'b0;
         rt_sign_q <= 1'b0;
         acc_q     <= '0;
         rem_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         op_q      <= op_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         rs_sign_q <= rs_sign_d;
         rt_sign_q <= rt_sign_d;
         acc_q     <= acc_d;
         rem_q     <= rem_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         dbz_q     <= dbz_d;
      end
   end

   assign bus.busy        = (state_q == S_CALC) || (state_q == S_FIX);
   assign bus.stall       = bus.busy & (bus.hilo_rd | bus.start);
   assign bus.done        = (state_q == S_DONE);
   assign bus.div_by_zero = dbz_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
endmodule

// File: tb/tb_md_sequencer.sv
// Directed + random bench for md_sequencer with a queue scoreboard of expected HI/LO results.
module tb_md_sequencer;
   localparam int W = 32;

   typedef struct {
      logic          dbz;
      logic [W-1:0]  hi;
      logic [W-1:0]  lo;
      int            lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   md_if #(.WIDTH(W)) bus();

   md_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   total  = 0;
   int   passes = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) passes++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      logic [63:0] p;
      e.dbz = 1'b0;
      e.lat = 34;
      e.hi  = '0;
      e.lo  = '0;
      case (op)
         2'b00: begin
            p = $signed(64'($signed(a))) * $signed(64'($signed(b)));
            e.hi = p[63:32]; e.lo = p[31:0];
         end
         2'b01: begin
            p = {32'd0, a} * {32'd0, b};
            e.hi = p[63:32]; e.lo = p[31:0];
         end
         default: begin
            if (b == '0) begin
               e.dbz = 1'b1; e.hi = a; e.lo = '1; e.lat = 1;
            end else if (op == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               e.lo = 32'h8000_0000; e.hi = '0;
            end else if (op == 2'b10) begin
               e.lo = $signed(a) / $signed(b);
               e.hi = $signed(a) % $signed(b);
            end else begin
               e.lo = a / b;
               e.hi = a % b;
            end
         end
      endcase
      return e;
   endfunction

   // Drives a start in an IDLE/DONE cycle; leaves the bench in cycle 1 of the op.
   task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.start = 1'b1;
      bus.md_op = op;
      bus.rs    = a;
      bus.rt    = b;
      exp_q.push_back(model(op, a, b));
      #1;
      chk("stall_when_not_busy", {63'd0, bus.stall}, 64'd0);
      tick();
      bus.start = 1'b0;
      bus.rs    = $urandom;
      bus.rt    = $urandom;
   endtask

   task automatic collect(input int cyc0, input string tag);
      int   cyc;
      exp_t e;
      cyc = cyc0;
      while (!bus.done && cyc < 60) begin
         tick();
         cyc++;
      end
      chk({tag, "_done"}, {63'd0, bus.done}, 64'd1);
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd1);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_latency"}, 64'(cyc), 64'(e.lat));
         chk({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, e.hi});
         chk({tag, "_lo"}, {32'd0, bus.lo}, {32'd0, e.lo});
         chk({tag, "_dbz"}, {63'd0, bus.div_by_zero}, {63'd0, e.dbz});
      end
   endtask

   initial begin
      logic [1:0]   op;
      logic [W-1:0] a, b;
      bus.start = 1'b0; bus.md_op = 2'b00; bus.rs = '0; bus.rt = '0; bus.hilo_rd = 1'b0;
      #1;
      chk("rst_busy", {63'd0, bus.busy}, 64'd0);
      chk("rst_done", {63'd0, bus.done}, 64'd0);
      chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
      chk("rst_dbz", {63'd0, bus.div_by_zero}, 64'd0);
      tick(); tick();
      rst = 1'b0;
      tick();

      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("t1_busy_c1", {63'd0, bus.busy}, 64'd1);
      collect(1, "t1_multu");
      chk("t1_hilo_const", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
      tick();
      chk("t1_idle_after_done", {62'd0, bus.busy, bus.done}, 64'd0);

      issue(2'b00, 32'hFFFF_FFFD, 32'd5);
      collect(1, "t2_mult");
      chk("t2_mult_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
      tick();
      issue(2'b10, 32'hFFFF_FFF9, 32'd2);
      collect(1, "t2_div");
      chk("t2_div_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      tick();

      issue(2'b11, 32'd100, 32'd0);
      chk("t3_busy_never", {63'd0, bus.busy}, 64'd0);
      collect(1, "t3_divu0");
      chk("t3_const", {bus.hi, bus.lo}, 64'h0000_0064_FFFF_FFFF);
      tick();
      chk("t3_busy_after", {63'd0, bus.busy}, 64'd0);

      issue(2'b01, 32'd6, 32'd7);
      repeat (4) tick();
      bus.start = 1'b1; bus.hilo_rd = 1'b1; bus.md_op = 2'b11; bus.rs = 32'd9; bus.rt = 32'd3;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t4_stall", {63'd0, bus.stall}, 64'd1);
         tick();
      end
      bus.start = 1'b0;
      #1;
      chk("t4_stall_hilo_only", {63'd0, bus.stall}, 64'd1);
      bus.hilo_rd = 1'b0;
      #1;
      chk("t4_no_stall", {63'd0, bus.stall}, 64'd0);
      collect(8, "t4_multu");
      chk("t4_const", {bus.hi, bus.lo}, 64'd42);
      tick();
      chk("t4_second_start_ignored", {62'd0, bus.busy, bus.done}, 64'd0);

      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      collect(1, "t5_ovf");
      chk("t5_const", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
      issue(2'b00, 32'd7, 32'hFFFF_FFFE);
      chk("t5_b2b_busy", {63'd0, bus.busy}, 64'd1);
      collect(1, "t5_b2b_mult");
      tick();

      issue(2'b11, 32'd1000, 32'd3);
      repeat (9) tick();
      rst = 1'b1;
      #1;
      chk("t6_rst_busy", {63'd0, bus.busy}, 64'd0);
      chk("t6_rst_hilo", {bus.hi, bus.lo}, 64'd0);
      exp_q.delete();
      tick();
      rst = 1'b0;
      tick();
      issue(2'b11, 32'd1000, 32'd3);
      collect(1, "t6_divu");
      chk("t6_const", {bus.hi, bus.lo}, {32'd1, 32'd333});
      tick();

      for (int i = 0; i < 6; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         b  = (i == 2) ? 32'd0 : $urandom;
         if (i == 2) op = 2'b10;
         issue(op, a, b);
         collect(1, "rand");
         tick();
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
